data_mem_arbiter: RTL and testbench

Two-core arbiter placed directly upstream of the shared data memory (DataMEM). It accepts load/store requests from core 0 and core 1 through a req/ack handshake and grants them with round-robin fairness. Each granted request becomes one single-cycle memory command; read data is returned to the requesting core. Out-of-range addresses are rejected without touching memory.

---
 rtl/data_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter between two cores and a shared data memory.
// Each granted request becomes one single-cycle memory command; all outputs are registered.
module data_mem_arbiter #(
  parameter int unsigned TAM  = 16,
  parameter int unsigned Lmem = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           reqLoad0,
  input  logic           reqLoad1,
  input  logic           reqWrite0,
  input  logic           reqWrite1,
  input  logic [TAM-1:0] reqADDR0,
  input  logic [TAM-1:0] reqADDR1,
  input  logic [TAM-1:0] reqDATA0,
  input  logic [TAM-1:0] reqDATA1,
  output logic           ack0,
  output logic           ack1,
  output logic           err0,
  output logic           err1,
  output logic [TAM-1:0] rdDATA0,
  output logic [TAM-1:0] rdDATA1,
  output logic [TAM-1:0] memADDR,
  output logic [TAM-1:0] memIN,
  output logic           memLoad,
  output logic           memWrite,
  input  logic [TAM-1:0] memOUT
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StDone} state_e;

  state_e         state_q;
  logic           last_grant_q;
  logic           gid_q;
  logic           op_write_q;

  logic           act0, act1, grant1;
  logic           sel_write, sel_bad;
  logic [TAM-1:0] sel_addr, sel_data;

  // On a tie the core that was not granted last wins.
  always_comb begin
    act0      = reqLoad0 | reqWrite0;
    act1      = reqLoad1 | reqWrite1;
    grant1    = act1 & (~act0 | ~last_grant_q);
    sel_write = grant1 ? reqWrite1 : reqWrite0;
    sel_addr  = grant1 ? reqADDR1 : reqADDR0;
    sel_data  = grant1 ? reqDATA1 : reqDATA0;
    sel_bad   = (sel_addr >> Lmem) != '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      gid_q        <= 1'b0;
      op_write_q   <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      rdDATA0      <= '0;
      rdDATA1      <= '0;
      memADDR      <= '0;
      memIN        <= '0;
      memLoad      <= 1'b0;
      memWrite     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (act0 | act1) begin
            gid_q        <= grant1;
            last_grant_q <= grant1;
            op_write_q   <= sel_write;
            if (sel_bad) begin
              // Rejected address: report straight away, memory untouched.
              if (grant1) begin
                ack1 <= 1'b1;
                err1 <= 1'b1;
                if (!sel_write) rdDATA1 <= '0;
              end else begin
                ack0 <= 1'b1;
                err0 <= 1'b1;
                if (!sel_write) rdDATA0 <= '0;
              end
              state_q <= StDone;
            end else begin
              memADDR  <= sel_addr;
              memIN    <= sel_data;
              memWrite <= sel_write;
              memLoad  <= ~sel_write;
              state_q  <= StIssue;
            end
          end
        end
        StIssue: begin
          memLoad  <= 1'b0;
          memWrite <= 1'b0;
          if (op_write_q) begin
            if (gid_q) ack1 <= 1'b1;
            else       ack0 <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          if (gid_q) begin
            rdDATA1 <= memOUT;
            ack1    <= 1'b1;
          end else begin
            rdDATA0 <= memOUT;
            ack0    <= 1'b1;
          end
          state_q <= StDone;
        end
        StDone: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          err0    <= 1'b0;
          err1    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random traffic from two cores,
// checked every cycle against a transaction-level timing and memory model.
module tb_data_mem_arbiter;

  localparam int unsigned MemWords = 256;

  typedef struct {
    bit          w;
    bit          both;
    logic [15:0] a;
    logic [15:0] d;
    int          gap;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqLoad0, reqLoad1, reqWrite0, reqWrite1;
  logic [15:0] reqADDR0, reqADDR1, reqDATA0, reqDATA1;
  logic        ack0, ack1, err0, err1;
  logic [15:0] rdDATA0, rdDATA1, memADDR, memIN, memOUT;
  logic        memLoad, memWrite;

  logic [1:0]  ack_v, err_v;
  logic [15:0] rd_v [2];
  assign ack_v   = {ack1, ack0};
  assign err_v   = {err1, err0};
  assign rd_v[0] = rdDATA0;
  assign rd_v[1] = rdDATA1;

  data_mem_arbiter #(.TAM(16), .Lmem(8)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .reqLoad0 (reqLoad0),
    .reqLoad1 (reqLoad1),
    .reqWrite0(reqWrite0),
    .reqWrite1(reqWrite1),
    .reqADDR0 (reqADDR0),
    .reqADDR1 (reqADDR1),
    .reqDATA0 (reqDATA0),
    .reqDATA1 (reqDATA1),
    .ack0     (ack0),
    .ack1     (ack1),
    .err0     (err0),
    .err1     (err1),
    .rdDATA0  (rdDATA0),
    .rdDATA1  (rdDATA1),
    .memADDR  (memADDR),
    .memIN    (memIN),
    .memLoad  (memLoad),
    .memWrite (memWrite),
    .memOUT   (memOUT)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Core drivers
  req_t q0[$], q1[$];
  req_t cur[2];
  bit   pres[2];
  int   wait_cnt[2];
  int   ack_log[$];

  // DataMEM stand-in
  logic [15:0] mem_arr[MemWords];
  bit          rd_pend;
  logic [7:0]  rd_a;

  // Reference model: arbiter as a sequence of timed transactions
  logic [15:0] ref_mem[MemWords];
  int          edge_n, free_at, last_g;
  int          ack_edge[2];
  bit          exp_err_f[2], exp_load_f[2];
  logic [15:0] exp_ld[2], exp_rd[2];
  int          st_edge;
  bit          st_w;
  logic [15:0] st_a, st_d;
  bit          rst_edge;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic req_t mk(bit w, logic [15:0] a, logic [15:0] d, int gap);
    req_t r;
    r.w = w; r.both = 1'b0; r.a = a; r.d = d; r.gap = gap;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.w    = 1'($urandom_range(0, 1));
    r.both = r.w & 1'($urandom_range(0, 1));
    r.a    = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535))
                                         : 16'($urandom_range(0, 31));
    r.d    = 16'($urandom());
    r.gap  = $urandom_range(0, 3);
    return r;
  endfunction

  task automatic model_reset();
    free_at = 0;
    last_g  = 1;
    st_edge = -1;
    for (int c = 0; c < 2; c++) begin
      ack_edge[c] = -1;
      exp_rd[c]   = '0;
    end
    rst_edge = 1'b1;
  endtask

  // Busy lengths from request sampling edge: error 2, write 3, load 4 cycles.
  task automatic model_edge();
    int c;
    bit bad;
    if (!rst) begin
      model_reset();
    end else if (edge_n >= free_at && (pres[0] || pres[1])) begin
      c = (pres[0] && pres[1]) ? ((last_g == 0) ? 1 : 0) : (pres[1] ? 1 : 0);
      last_g = c;
      bad = int'(cur[c].a) >= MemWords;
      exp_err_f[c]  = bad;
      exp_load_f[c] = !cur[c].w;
      if (bad) begin
        ack_edge[c] = edge_n;
        free_at     = edge_n + 2;
        exp_ld[c]   = '0;
      end else begin
        st_edge = edge_n;
        st_w    = cur[c].w;
        st_a    = cur[c].a;
        st_d    = cur[c].d;
        if (cur[c].w) begin
          ref_mem[cur[c].a[7:0]] = cur[c].d;
          ack_edge[c] = edge_n + 1;
          free_at     = edge_n + 3;
        end else begin
          exp_ld[c]   = ref_mem[cur[c].a[7:0]];
          ack_edge[c] = edge_n + 2;
          free_at     = edge_n + 4;
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit ae, se;
    for (int c = 0; c < 2; c++) begin
      ae = (ack_edge[c] == edge_n);
      if (ae && exp_load_f[c]) exp_rd[c] = exp_ld[c];
      check_eq($sformatf("ack%0d", c), ack_v[c], ae);
      check_eq($sformatf("err%0d", c), err_v[c], ae && exp_err_f[c]);
      check_eq($sformatf("rdDATA%0d", c), rd_v[c], exp_rd[c]);
    end
    se = (st_edge == edge_n);
    check_eq("memWrite", memWrite, se && st_w);
    check_eq("memLoad", memLoad, se && !st_w);
    if (se) check_eq("memADDR", memADDR, st_a);
    if (se && st_w) check_eq("memIN", memIN, st_d);
    if (rst_edge) begin
      check_eq("memADDR_rst", memADDR, 0);
      check_eq("memIN_rst", memIN, 0);
      rst_edge = 1'b0;
    end
  endtask

  task automatic mem_model();
    memOUT  = rd_pend ? mem_arr[rd_a] : 16'($urandom());
    rd_pend = memLoad;
    rd_a    = memADDR[7:0];
    if (memWrite) mem_arr[memADDR[7:0]] = memIN;
  endtask

  task automatic drive_cores();
    for (int c = 0; c < 2; c++) begin
      if (pres[c] && ack_v[c]) begin
        pres[c] = 1'b0;
        ack_log.push_back(c);
      end else if (!pres[c]) begin
        if (c == 0 && q0.size() > 0) begin
          if (wait_cnt[0] < q0[0].gap) wait_cnt[0]++;
          else begin cur[0] = q0.pop_front(); pres[0] = 1'b1; wait_cnt[0] = 0; end
        end
        if (c == 1 && q1.size() > 0) begin
          if (wait_cnt[1] < q1[0].gap) wait_cnt[1]++;
          else begin cur[1] = q1.pop_front(); pres[1] = 1'b1; wait_cnt[1] = 0; end
        end
      end
    end
    reqLoad0  = pres[0] && (!cur[0].w || cur[0].both);
    reqWrite0 = pres[0] && cur[0].w;
    reqADDR0  = cur[0].a;
    reqDATA0  = cur[0].d;
    reqLoad1  = pres[1] && (!cur[1].w || cur[1].both);
    reqWrite1 = pres[1] && cur[1].w;
    reqADDR1  = cur[1].a;
    reqDATA1  = cur[1].d;
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    @(negedge clk);
    check_outputs();
    mem_model();
    drive_cores();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    bit drained;
    drained = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && !pres[0] && !pres[1] && edge_n >= free_at) begin
        drained = 1'b1;
        break;
      end
      step();
    end
    check_eq({tag, "_drained"}, drained, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    for (int i = 0; i < int'(MemWords); i++) begin
      mem_arr[i] = 16'($urandom());
      ref_mem[i] = mem_arr[i];
    end
    edge_n  = 0;
    rd_pend = 1'b0;
    memOUT  = '0;
    cur[0]  = mk(1'b0, '0, '0, 0);
    cur[1]  = mk(1'b0, '0, '0, 0);
    model_reset();

    // Reset held with a pending write, then the write/read pair from core 0
    rst = 1'b0;
    q0.push_back(mk(1'b1, 16'h0012, 16'hBEEF, 0));
    q0.push_back(mk(1'b0, 16'h0012, 16'h0000, 0));
    drive_cores();
    repeat (3) step();
    rst = 1'b1;
    run_until_idle("wr_rd", 50);
    check_eq("rd_beef", rdDATA0, 16'hBEEF);

    // Tie with core 0 favoured (last grant still core 0 -> make core 1 go once first)
    q1.push_back(mk(1'b0, 16'h0012, 16'h0000, 0));
    run_until_idle("pre_tie", 50);
    ack_log.delete();
    q0.push_back(mk(1'b1, 16'h0001, 16'h1111, 0));
    q1.push_back(mk(1'b1, 16'h0002, 16'h2222, 0));
    run_until_idle("tie1", 50);
    check_eq("tie1_n", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      check_eq("tie1_first", ack_log[0], 0);
      check_eq("tie1_second", ack_log[1], 1);
    end

    // Read back: core 1 first, core 0 later, leaving last grant on core 0
    q1.push_back(mk(1'b0, 16'h0002, 16'h0000, 0));
    q0.push_back(mk(1'b0, 16'h0001, 16'h0000, 8));
    run_until_idle("readback", 50);
    check_eq("rb_core0", rdDATA0, 16'h1111);
    check_eq("rb_core1", rdDATA1, 16'h2222);

    ack_log.delete();
    q0.push_back(mk(1'b1, 16'h0003, 16'h3333, 0));
    q1.push_back(mk(1'b1, 16'h0004, 16'h4444, 0));
    run_until_idle("tie2", 50);
    check_eq("tie2_n", ack_log.size(), 2);
    if (ack_log.size() == 2) check_eq("tie2_first", ack_log[0], 1);

    // Out-of-range load by core 1
    q1.push_back(mk(1'b0, 16'h0100, 16'h0000, 0));
    run_until_idle("bad_addr", 50);
    check_eq("bad_rd1", rdDATA1, 0);

    // Continuous traffic from both cores: strict alternation
    ack_log.delete();
    for (int i = 0; i < 5; i++) begin
      q0.push_back(mk(1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom()), 0));
      q1.push_back(mk(1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom()), 0));
    end
    run_until_idle("alt", 200);
    check_eq("alt_n", ack_log.size(), 10);
    for (int i = 0; i < ack_log.size(); i++) check_eq($sformatf("alt_%0d", i), ack_log[i], i % 2);

    // Reset during the capture cycle of a core 0 load
    ack_log.delete();
    hit = 1'b0;
    q0.push_back(mk(1'b0, 16'h0003, 16'h0000, 0));
    for (int i = 0; i < 20; i++) begin
      step();
      if (st_edge >= 0 && st_edge == edge_n - 1 && !st_w) begin
        hit = 1'b1;
        rst = 1'b0;
        step();
        rst = 1'b1;
        break;
      end
    end
    check_eq("rst_capture_hit", hit, 1);
    run_until_idle("rst_mid", 50);
    check_eq("rst_mid_acks", ack_log.size(), 1);
    check_eq("rst_mid_rd", rdDATA0, 16'h3333);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      q0.push_back(rand_req());
      q1.push_back(rand_req());
    end
    run_until_idle("random", 5000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
